// File: rtl/seg7_count_display.sv
// Two-digit multiplexed 7-segment display for the active-low 6-bit LED counter.
// A sequential double-dabble engine converts the value to BCD; leading zero on tens is blanked.
module seg7_count_display #(
    parameter int CLK_FREQ     = 27000000,
    parameter int REFRESH_HZ   = 1000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] count_n_i,
    output logic [6:0] seg_o,
    output logic [1:0] dig_o,
    output logic       busy_o
);

    localparam int DIV = CLK_FREQ / REFRESH_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;

    logic [1:0]    state_q;
    logic [5:0]    cnt_q;
    logic [5:0]    last_q;
    logic [5:0]    conv_q;
    logic [5:0]    bin_r;
    logic [7:0]    bcd_r;
    logic [7:0]    bcd_adj;
    logic [13:0]   shifted;
    logic [2:0]    step_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic          busy_q;

    logic [CW-1:0] refresh_q;
    logic          sel_q;

    logic [3:0]    digit_sel;
    logic [6:0]    seg_ah;
    logic [6:0]    seg_next;
    logic [1:0]    dig_next;
    logic [6:0]    seg_q;
    logic [1:0]    dig_q;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_r[gi*4 +: 4] >= 4'd5) ?
                                    bcd_r[gi*4 +: 4] + 4'd3 : bcd_r[gi*4 +: 4];
    end

    assign shifted = {bcd_adj, bin_r} << 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            last_q  <= 6'd0;
            conv_q  <= 6'd0;
            bin_r   <= 6'd0;
            bcd_r   <= 8'h00;
            step_q  <= 3'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q <= ~count_n_i;
            case (state_q)
                IDLE: begin
                    if (cnt_q != last_q) begin
                        bin_r   <= cnt_q;
                        conv_q  <= cnt_q;
                        bcd_r   <= 8'h00;
                        step_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_r  <= shifted[13:6];
                    bin_r  <= shifted[5:0];
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd5) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    tens_q  <= bcd_r[7:4];
                    ones_q  <= bcd_r[3:0];
                    // Remember what was converted so a change during conversion is re-detected.
                    last_q  <= conv_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_q <= '0;
            sel_q     <= 1'b0;
        end else if (refresh_q == DIV_LAST) begin
            refresh_q <= '0;
            sel_q     <= ~sel_q;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        digit_sel = sel_q ? tens_q : ones_q;
        seg_ah    = decode(digit_sel);
        if (sel_q && (tens_q == 4'd0)) begin
            seg_ah = 7'h00;
        end
        seg_next = COMMON_ANODE ? ~seg_ah : seg_ah;
        dig_next = sel_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_q <= SEG_OFF;
            dig_q <= 2'b11;
        end else begin
            seg_q <= seg_next;
            dig_q <= dig_next;
        end
    end

    assign seg_o  = seg_q;
    assign dig_o  = dig_q;
    assign busy_o = busy_q;

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
Downstream consumer of the 6-bit free-running LED counter output (active-low, 0..63). It converts the value to two BCD digits with a sequential double-dabble engine. It drives a time-multiplexed 2-digit 7-segment display with leading-zero blanking. It sits between the counter stage and the board's segment/digit pins.

Parameters:
CLK_FREQ, 27000000, clk frequency in Hz.
REFRESH_HZ, 1000, digit-switch rate in Hz. Divider DIV = CLK_FREQ/REFRESH_HZ; the refresh counter runs 0..DIV-1. DIV >= 2.
COMMON_ANODE, 1, 1: seg_o active-low. 0: seg_o active-high.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-low reset.
count_n_i  in  6  counter value, active-low (bitwise inverted binary).
seg_o  out  7  segments; bit0=a … bit6=g; polarity set by COMMON_ANODE.
dig_o  out  2  digit enables, always active-low; bit0=ones, bit1=tens.
busy_o  out  1  high while a conversion is in progress.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, cnt_q=0, last_q=0, tens_q=0, ones_q=0.
  - Refresh counter=0, sel_q=0 (ones digit).
  - busy_o=0, dig_o=2'b11, seg_o=all segments off (7'h7F when COMMON_ANODE=1).
- Input register: each edge, cnt_q <= ~count_n_i.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: if cnt_q != last_q, load bin_r=cnt_q, bcd_r=8'h00, i=0, go to SHIFT, busy_o<=1. Otherwise stay.
  - SHIFT, one step per edge, 6 steps:
    - Add 3 to each BCD nibble that is >=5.
    - Shift {bcd_r,bin_r} left by 1.
    - i++; after step 6 go to LOAD.
  - LOAD: tens_q<=bcd_r[7:4], ones_q<=bcd_r[3:0], last_q<=converted value, busy_o<=0, go to IDLE.
- Latency: input captured at edge N -> start at N+1 -> shifts N+2..N+7 -> digit registers update at N+8. busy_o is high N+1..N+7.
- Input changes during SHIFT/LOAD do not affect the running conversion. The new value is re-detected in IDLE on the edge after LOAD (last_q holds the converted value). No value is lost as long as the input is stable for 9+ cycles.
- Refresh: the counter wraps at DIV-1 and sel_q toggles on wrap.
- Output stage (registered each edge from sel_q, tens_q, ones_q; 1-cycle lag):
  - sel_q=0: dig_o=2'b10, ones digit.
  - sel_q=1: dig_o=2'b01, tens digit.
- Active-high encoding: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Nibble >9 shows blank. For COMMON_ANODE=1, seg_o is the bitwise inverse.
- Leading-zero blank: when tens_q=0, the tens phase shows all segments off and dig_o still cycles. Value 0 shows "0" on the ones digit.
- Reset mid-conversion aborts immediately; all state returns to reset values. The first edge after release shows "0" on ones.

Test Plan:
(bench: CLK_FREQ=100, REFRESH_HZ=10 -> DIV=10)
1. rst=0 for 3 cycles -> seg_o=7'h7F, dig_o=2'b11, busy_o=0. First edge after release -> dig_o=2'b10, seg_o=7'h40 ("0"). No busy pulse.
2. count_n_i=6'b010101 (value 42), captured at N -> busy_o=1 N+1..N+7. Digits 4/2 at N+8. Ones phase seg_o=7'h24, tens phase seg_o=7'h19.
3. count_n_i=6'b000000 (63) -> ones seg_o=7'h30 ("3"), tens seg_o=7'h02 ("6"). Value 7 -> tens phase seg_o=7'h7F (blanked), ones 7'h78.
4. Value 10 at N, changed to 11 at N+3 -> display shows 10 at N+8. Second conversion starts at N+9; display shows 11 at N+16.
5. Refresh: static value 42 -> dig_o holds 2'b10 for 10 cycles, then 2'b01 for 10 cycles, repeating. seg_o tracks the selected digit with a 1-cycle lag.
6. rst=0 asserted during SHIFT step 3 of value 42 -> busy_o=0 and display "0" after release. Input still 42 -> reconversion completes and 42 appears 9 cycles after release.
